// File: rtl/matrix_scan_sched_pkg.sv
// -----------------------------------------------------------------------------
// matrix_scan_sched_pkg
// Shared types, constants and helpers for the scan scheduler.
//   state_e      : scheduler states (IDLE / SHOW / SWEEP)
//   BLANK_NIBBLE : key buffer code for an empty position, also the blank glyph
//   ROW_INIT     : one-hot row strobe at reset and at every frame start
//   CHAR_STRIDE  : character ROM bytes per glyph
//   NUM_DIGITS   : digits held in the key buffer
//   nibble_at()  : extract nibble idx (0 = newest) from the key buffer
//   char_base()  : ROM base address of a nibble's glyph (0 = blank glyph)
// -----------------------------------------------------------------------------
package matrix_scan_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [7:0] ROW_INIT     = 8'b1000_0000;
    localparam logic [7:0] CHAR_STRIDE  = 8'd8;
    localparam int         NUM_DIGITS   = 6;

    function automatic logic [3:0] nibble_at(input logic [23:0] kc, input logic [2:0] idx);
        logic [23:0] shifted;
        shifted = kc >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    // Glyph 0 is the blank character, so digit n lives at (n+1)*stride.
    // Anything that is not a decimal digit (including the empty code) is blank.
    function automatic logic [7:0] char_base(input logic [3:0] n);
        if (n > 4'd9) begin
            return 8'd0;
        end
        return ({4'd0, n} + 8'd1) * CHAR_STRIDE;
    endfunction

endpackage

// File: rtl/matrix_scan_sched_if.sv
// -----------------------------------------------------------------------------
// matrix_scan_sched_if
// Bundle between the key buffer / display path and the scan scheduler.
//   key_code   : six BCD nibbles, [3:0] newest, [23:20] oldest, 4'hF empty
//   key_valid  : one-cycle pulse, key_code has just shifted in a new digit
//   sel, digit : digit/keypad select 0..5 and the nibble for that select
//   row        : one-hot matrix row enable
//   rom_addr   : character ROM address (glyph base + row index)
//   frame_done : one-cycle pulse after the tick that completes row index 7
//   busy       : scheduler is not in IDLE
//   dbg_state  : current scheduler state, for observation only
// Handshake: key_valid is a pulse with no back-pressure. The scheduler always
// accepts it; pulses arriving within one frame merge, and the most recent
// key_code seen at the frame start is the one shown.
// master = key buffer side, slave = scheduler.
// -----------------------------------------------------------------------------
interface matrix_scan_sched_if;
    import matrix_scan_sched_pkg::*;

    logic [23:0] key_code;
    logic        key_valid;
    logic [2:0]  sel;
    logic [3:0]  digit;
    logic [7:0]  row;
    logic [7:0]  rom_addr;
    logic        frame_done;
    logic        busy;
    state_e      dbg_state;

    modport master (
        output key_code, key_valid,
        input  sel, digit, row, rom_addr, frame_done, busy, dbg_state
    );

    modport slave (
        input  key_code, key_valid,
        output sel, digit, row, rom_addr, frame_done, busy, dbg_state
    );

endinterface

// File: rtl/matrix_scan_sched_tick.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider producing a one-clk scan tick enable.
//   clk   : system clock
//   reset : asynchronous, active-low
//   tick  : high for one clk when the counter sits at DIV-1; the counter then
//           wraps to 0, so the first tick after reset is DIV cycles later
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int DIV = 8192
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_scan_sched.sv
// -----------------------------------------------------------------------------
// matrix_scan_sched
// Scan scheduler for the keypad/display board: drives the shared digit select,
// the 8x8 matrix row strobe and the character ROM address from one clock, and
// chooses which buffered key digit the matrix shows. Glyph changes are taken
// only at frame starts (row index wrapping 7 -> 0) so characters never tear.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : matrix_scan_sched_if.slave (key buffer in, scan outputs out)
// Parameters:
//   TICK_DIV    : clk cycles per scan tick (>= 2)
//   HOLD_FRAMES : frames each character dwells while idle / sweeping (>= 1)
// Build option:
//   MATRIX_SWEEP_EN : when defined, after HOLD_FRAMES frames without a new key
//                     the matrix sweeps through all six buffered digits,
//                     oldest first, and then returns to the newest digit.
//                     Undefined: the newest digit is shown indefinitely.
// -----------------------------------------------------------------------------
module matrix_scan_sched
    import matrix_scan_sched_pkg::*;
#(
    parameter int TICK_DIV    = 8192,
    parameter int HOLD_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset,
    matrix_scan_sched_if.slave bus
);

    localparam logic [2:0] SEL_LAST = 3'(NUM_DIGITS - 1);

    logic       tick;
    logic       frame_start;
    logic       take_key;

    logic [2:0] r_q, r_nxt;
    logic [7:0] row_q;
    logic [2:0] sel_q, sel_nxt;
    logic [3:0] digit_q;
    logic [7:0] rom_q;
    logic [7:0] cb_q, cb_nxt;
    logic       fd_q;
    logic       pend_q;

    state_e     state_q, state_d;
    logic       busy_w;
    logic [3:0] show_nib;

`ifdef MATRIX_SWEEP_EN
    localparam int IDLE_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [IDLE_W-1:0] HOLD_LAST = IDLE_W'(HOLD_FRAMES - 1);

    // Frames already completed in the current dwell. Reaching HOLD_FRAMES is
    // acted on immediately, so the stored value never exceeds HOLD_FRAMES-1.
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [2:0]        k_q, k_d;
`endif

    scan_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign frame_start = tick && (r_q == 3'd7);
    // A key_valid coinciding with the frame-start tick counts for that frame.
    assign take_key    = frame_start && (pend_q || bus.key_valid);
    assign r_nxt       = r_q + 3'd1;
    assign sel_nxt     = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
`ifdef MATRIX_SWEEP_EN
            idle_q  <= '0;
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MATRIX_SWEEP_EN
            idle_q  <= idle_d;
            k_q     <= k_d;
`endif
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
`ifdef MATRIX_SWEEP_EN
        idle_d  = idle_q;
        k_d     = k_q;
`endif
        if (take_key) begin
            // New key wins from any state, including an ongoing sweep.
            state_d = SHOW;
`ifdef MATRIX_SWEEP_EN
            idle_d  = '0;
`endif
        end else if (frame_start) begin
            case (state_q)
                IDLE: state_d = IDLE;
                SHOW: begin
`ifdef MATRIX_SWEEP_EN
                    if (idle_q == HOLD_LAST) begin
                        state_d = SWEEP;
                        k_d     = SEL_LAST;
                        idle_d  = '0;
                    end else begin
                        idle_d  = idle_q + 1'b1;
                    end
`else
                    state_d = SHOW;
`endif
                end
`ifdef MATRIX_SWEEP_EN
                SWEEP: begin
                    if (idle_q == HOLD_LAST) begin
                        idle_d = '0;
                        if (k_q == 3'd0) begin
                            state_d = SHOW;
                        end else begin
                            k_d = k_q - 3'd1;
                        end
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // show_nib is the glyph for the state being entered; it is only consumed
    // at a frame start, where state_d is the state of the frame beginning.
    always_comb begin
        busy_w   = (state_q != IDLE);
        show_nib = BLANK_NIBBLE;
        case (state_d)
            SHOW:  show_nib = bus.key_code[3:0];
`ifdef MATRIX_SWEEP_EN
            SWEEP: show_nib = nibble_at(bus.key_code, k_d);
`endif
            default: show_nib = BLANK_NIBBLE;
        endcase
        cb_nxt = char_base(show_nib);
    end

    // ---------------- scan datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= 3'd0;
            row_q   <= ROW_INIT;
            sel_q   <= 3'd0;
            digit_q <= BLANK_NIBBLE;
            rom_q   <= 8'd0;
            cb_q    <= 8'd0;
            fd_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            fd_q <= frame_start;
            if (take_key) begin
                pend_q <= 1'b0;
            end else if (bus.key_valid) begin
                pend_q <= 1'b1;
            end
            if (tick) begin
                r_q     <= r_nxt;
                row_q   <= {row_q[0], row_q[7:1]};
                sel_q   <= sel_nxt;
                // sel 5 shows the newest nibble, sel 0 the oldest.
                digit_q <= nibble_at(bus.key_code, SEL_LAST - sel_nxt);
                if (frame_start) begin
                    cb_q  <= cb_nxt;
                    rom_q <= cb_nxt + {5'd0, r_nxt};
                end else begin
                    rom_q <= cb_q + {5'd0, r_nxt};
                end
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.digit      = digit_q;
    assign bus.row        = row_q;
    assign bus.rom_addr   = rom_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = busy_w;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_matrix_scan_sched.sv
// -----------------------------------------------------------------------------
// tb_matrix_scan_sched
// Self-checking bench for matrix_scan_sched with TICK_DIV=4, HOLD_FRAMES=2.
// The reference model works on whole ticks and frames: tick number t gives
// sel, row and row index directly, and the glyph of a frame follows from how
// many frames have passed since the last accepted key. Build with
// MATRIX_SWEEP_EN defined to exercise the sweep.
// -----------------------------------------------------------------------------
module tb_matrix_scan_sched;
    import matrix_scan_sched_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int HOLD_FRAMES = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matrix_scan_sched_if bus ();

    matrix_scan_sched #(
        .TICK_DIV    (TICK_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int          m_cyc;
    int          m_t;
    int          m_r;
    int          m_key_frame;
    bit          m_applied;
    bit          m_pend;
    logic [2:0]  m_sel;
    logic [3:0]  m_digit;
    logic [7:0]  m_row;
    logic [7:0]  m_rom;
    logic [7:0]  m_cb;
    logic        m_fd;
    state_e      m_state;
    logic [23:0] cur_kc;

    function automatic logic [3:0] tb_nib(input logic [23:0] kc, input int i);
        logic [23:0] s;
        s = kc >> (4 * i);
        return s[3:0];
    endfunction

    function automatic logic [7:0] tb_glyph(input logic [3:0] n);
        int v;
        v = (n <= 4'd9) ? (int'(n) + 1) * 8 : 0;
        return 8'(v);
    endfunction

    task automatic model_reset();
        m_cyc       = 0;
        m_t         = 0;
        m_r         = 0;
        m_key_frame = 0;
        m_applied   = 0;
        m_pend      = 0;
        m_sel       = 3'd0;
        m_digit     = 4'hF;
        m_row       = 8'h80;
        m_rom       = 8'd0;
        m_cb        = 8'd0;
        m_fd        = 1'b0;
        m_state     = IDLE;
    endtask

    // Glyph for frame f: blank before any key; otherwise d frames after the
    // last key the display runs in periods of 7*HOLD frames: HOLD frames of the
    // newest digit, then six HOLD-frame slots oldest to newest (sweep builds).
    task automatic frame_char(input int f, input logic [23:0] kc);
        logic [3:0] n;
        int d;
        int idx;
        if (!m_applied) begin
            m_state = IDLE;
            n = 4'hF;
        end else begin
            d = f - m_key_frame;
`ifdef MATRIX_SWEEP_EN
            idx = (d / HOLD_FRAMES) % 7;
`else
            idx = 0;
`endif
            if (idx == 0) begin
                m_state = SHOW;
                n = kc[3:0];
            end else begin
                m_state = SWEEP;
                n = tb_nib(kc, 6 - idx);
            end
        end
        m_cb = tb_glyph(n);
    endtask

    task automatic model_edge(input logic kv, input logic [23:0] kc);
        m_cyc++;
        m_fd = 1'b0;
        if (m_cyc % TICK_DIV == 0) begin
            m_t     = m_cyc / TICK_DIV;
            m_sel   = 3'(m_t % 6);
            m_digit = tb_nib(kc, 5 - (m_t % 6));
            m_r     = m_t % 8;
            m_row   = 8'h80 >> m_r;
            if (m_r == 0) begin
                m_fd = 1'b1;
                if (m_pend || kv) begin
                    m_applied   = 1;
                    m_key_frame = m_t / 8;
                    m_pend      = 0;
                end
                frame_char(m_t / 8, kc);
            end else if (kv) begin
                m_pend = 1;
            end
            m_rom = m_cb + 8'(m_r);
        end else if (kv) begin
            m_pend = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sel",        32'(bus.sel),        32'(m_sel));
        chk("digit",      32'(bus.digit),      32'(m_digit));
        chk("row",        32'(bus.row),        32'(m_row));
        chk("rom_addr",   32'(bus.rom_addr),   32'(m_rom));
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        chk("busy",       32'(bus.busy),       32'(m_applied));
        chk("state",      32'(bus.dbg_state),  32'(m_state));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sel"},   32'(bus.sel),        32'd0);
        chk({tag, "_digit"}, 32'(bus.digit),      32'hF);
        chk({tag, "_row"},   32'(bus.row),        32'h80);
        chk({tag, "_rom"},   32'(bus.rom_addr),   32'd0);
        chk({tag, "_fd"},    32'(bus.frame_done), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),       32'd0);
        chk({tag, "_state"}, 32'(bus.dbg_state),  32'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc_step(input logic kv, input logic [23:0] kc);
        bus.key_valid = kv;
        bus.key_code  = kc;
        @(posedge clk);
        model_edge(kv, kc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(1'b0, cur_kc);
    endtask

    task automatic key(input logic [23:0] kc);
        cur_kc = kc;
        cyc_step(1'b1, kc);
    endtask

    // Advance until the next clock edge lands at cycle offset pos of a frame.
    task automatic goto_pos(input int pos);
        for (int i = 0; i < 8 * TICK_DIV; i++) begin
            if ((m_cyc + 1) % (8 * TICK_DIV) == pos) break;
            idle(1);
        end
    endtask

    task automatic do_reset_mid_run();
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("held_rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    localparam int FRAME = 8 * TICK_DIV;

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [23:0] kc;
        logic        kv;
        cur_kc        = 24'hFFFFFF;
        bus.key_code  = cur_kc;
        bus.key_valid = 1'b0;
        reset         = 1'b0;
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        // No keys: sel/row/rom scan, blank glyph, not busy.
        idle(2 * FRAME + 8);

        // Key 3 mid-frame: blank until the next frame start, then 32..39.
        goto_pos(10);
        key(24'hFFFFF3);
        idle(FRAME + 4);

        // Digit mapping with key_code 123456 over a full sel cycle.
        key(24'h123456);
        idle(FRAME);

        // Two keys inside one frame: only the latest (9) is shown.
        goto_pos(4);
        key(24'h234567);
        idle(6);
        key(24'h345679);
        idle(2 * FRAME);

        // Key on the frame-start tick cycle itself.
        goto_pos(0);
        key(24'h456798);
        idle(FRAME);

        // Sweep sequence with blanks, back to the newest digit, then abort.
        key(24'hFF1234);
        idle(16 * FRAME);
        idle(2 * FRAME + 9);
        key(24'hF12345);
        idle(3 * FRAME);

        // Randomized key traffic, including non-decimal nibbles.
        for (int i = 0; i < 600; i++) begin
            kv = ($urandom_range(0, 24) == 0);
            if (kv) begin
                kc = {cur_kc[19:0], 4'($urandom_range(0, 15))};
                key(kc);
            end else begin
                idle(1);
            end
        end

        // Reset while sweeping, then resume cleanly from reset.
        key(24'h987654);
        idle(5 * FRAME + 13);
        do_reset_mid_run();
        idle(FRAME + 3);
        key(24'hFFFFF1);
        idle(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
